// File: rtl/sa_result_drain.sv
`default_nettype none
// ------------------------------------------------------------------------
// sa_result_drain: captures the systolic-array result matrix, requantises it
// to int8 and streams it row by row. Optional macro: SA_RESULT_DRAIN_RELU_EN.
// Revision: 1.0
// ------------------------------------------------------------------------
module sa_result_drain #(
  parameter int N       = 8,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [N*N*32-1:0]      i_c,
  input  logic                   i_validResult,
  input  logic [MULT_W-1:0]      i_scaleMult,
  input  logic [SHIFT_W-1:0]     i_scaleShift,
  input  logic                   i_rowReady,
  output logic                   o_rowValid,
  output logic [N*8-1:0]         o_row,
  output logic [$clog2(N)-1:0]   o_rowIdx,
  output logic                   o_rowLast,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam int IDX_W  = $clog2(N);
  localparam int PROD_W = 33 + MULT_W;
  // One extra bit so the rounding addend can never wrap the product.
  localparam int SUM_W  = PROD_W + 1;

  generate
    if (N < 3 || N > 256) begin : g_bad_n
      $error("sa_result_drain: N must be in 3..256");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   capture, load, advance, finish;

  logic [IDX_W-1:0]              ptr;
  logic [N-1:0][N-1:0][31:0]     mat;
  logic [MULT_W-1:0]             mult_q;
  logic [SHIFT_W-1:0]            shift_q;
  logic [N*8-1:0]                row_sel;

  function automatic logic signed [7:0] requant(
    input logic signed [31:0]  acc,
    input logic [MULT_W-1:0]   mult,
    input logic [SHIFT_W-1:0]  shift
  );
    logic signed [PROD_W-1:0] acc_x;
    logic signed [PROD_W-1:0] mult_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  rnd;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  res;
    logic signed [7:0]        sat;
    acc_x  = PROD_W'(acc);
    mult_x = PROD_W'($signed({1'b0, mult}));
    prod   = acc_x * mult_x;
    rnd    = '0;
    if (shift != '0) rnd = SUM_W'(1) << (shift - SHIFT_W'(1));
    sum = SUM_W'(prod) + rnd;
    res = sum >>> shift;
    if (res > SUM_W'(127))       sat = 8'sd127;
    else if (res < SUM_W'(-128)) sat = -8'sd128;
    else                         sat = res[7:0];
`ifdef SA_RESULT_DRAIN_RELU_EN
    if (sat[7]) sat = '0;
`endif
    return sat;
  endfunction

  generate
    for (genvar col = 0; col < N; col++) begin : g_col
      assign row_sel[col*8 +: 8] = requant(mat[ptr][col], mult_q, shift_q);
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (i_validResult) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (i_rowReady) begin
          if (ptr == IDX_W'(N - 1)) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state      <= IDLE;
      ptr        <= '0;
      o_rowValid <= 1'b0;
      o_row      <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (i_validResult && state != IDLE) o_overflow <= 1'b1;
      if (capture) ptr <= '0;
      if (load) begin
        o_row      <= row_sel;
        o_rowValid <= 1'b1;
      end
      if (advance) begin
        ptr        <= ptr + IDX_W'(1);
        o_rowValid <= 1'b0;
      end
      if (finish) begin
        ptr        <= '0;
        o_rowValid <= 1'b0;
      end
    end
  end

  // The capture buffer needs no reset: it is only read after a capture.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      mat     <= i_c;
      mult_q  <= i_scaleMult;
      shift_q <= i_scaleShift;
    end
  end

  assign o_rowIdx  = ptr;
  assign o_rowLast = o_rowValid && (ptr == IDX_W'(N - 1));
  assign o_busy    = (state != IDLE);

endmodule
`default_nettype wire
